// File: rtl/bp_lce_mem_pkt_arbiter_pkg.sv
// Shared grant encoding and sizing helper for the LCE mem-packet arbiter.
// The grant encoding doubles as the one-hot {cmd,fill} owner_o debug value.
package bp_lce_mem_pkt_arbiter_pkg;

  typedef enum logic [1:0] {
    e_grant_none = 2'b00,
    e_grant_fill = 2'b01,
    e_grant_cmd  = 2'b10
  } bp_lce_grant_e;

  localparam int unsigned starve_limit_default_lp = 8;

  // Width needed to hold 0..limit; a limit below 1 is invalid, so clamp to one bit.
  function automatic int unsigned starve_cnt_width(input int unsigned limit);
    if (limit < 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(limit + 32'd1);
    end
  endfunction

endpackage

// File: rtl/bp_lce_mem_pkt_arbiter_starve_cnt.sv
// Saturating up/clear counter with asynchronous active-low reset.
// Clear wins over up; the count parks at max_val_p until cleared.
module bp_lce_mem_pkt_arbiter_starve_cnt
  import bp_lce_mem_pkt_arbiter_pkg::*;
  #(parameter int unsigned max_val_p = starve_limit_default_lp
   ,parameter int unsigned width_p   = starve_cnt_width(max_val_p))
  (input  logic               clk_i
  ,input  logic               reset_n_i
  ,input  logic               clear_i
  ,input  logic               up_i
  ,output logic [width_p-1:0] count_o
  ,output logic               sat_o
  );

  localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

  logic [width_p-1:0] count_d, count_q;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (up_i && (count_q != max_lp)) begin
      count_d = count_q + width_p'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = (count_q == max_lp);

endmodule

// File: rtl/bp_lce_mem_pkt_arbiter.sv
// Shares the cache tag/data mem-packet ports between the LCE Fill and Command
// engines: zero-latency forwarding, ownership lock across multi-packet transactions.
module bp_lce_mem_pkt_arbiter
  import bp_lce_mem_pkt_arbiter_pkg::*;
  #(parameter int unsigned tag_pkt_width_p  = 0
   ,parameter int unsigned data_pkt_width_p = 0
   ,parameter int unsigned starve_limit_p   = starve_limit_default_lp
   ,localparam int unsigned tag_w_lp  = (tag_pkt_width_p  == 0) ? 1 : tag_pkt_width_p
   ,localparam int unsigned data_w_lp = (data_pkt_width_p == 0) ? 1 : data_pkt_width_p
   ,localparam int unsigned starve_w_lp = starve_cnt_width(starve_limit_p))
  (input  logic                 clk_i
  ,input  logic                 reset_n_i

  ,input  logic                 fill_tag_v_i
  ,input  logic [tag_w_lp-1:0]  fill_tag_i
  ,input  logic                 fill_tag_last_i
  ,output logic                 fill_tag_yumi_o
  ,input  logic                 fill_data_v_i
  ,input  logic [data_w_lp-1:0] fill_data_i
  ,input  logic                 fill_data_last_i
  ,output logic                 fill_data_yumi_o

  ,input  logic                 cmd_tag_v_i
  ,input  logic [tag_w_lp-1:0]  cmd_tag_i
  ,input  logic                 cmd_tag_last_i
  ,output logic                 cmd_tag_yumi_o
  ,input  logic                 cmd_data_v_i
  ,input  logic [data_w_lp-1:0] cmd_data_i
  ,input  logic                 cmd_data_last_i
  ,output logic                 cmd_data_yumi_o

  ,output logic                 tag_mem_pkt_v_o
  ,output logic [tag_w_lp-1:0]  tag_mem_pkt_o
  ,input  logic                 tag_mem_pkt_yumi_i
  ,output logic                 data_mem_pkt_v_o
  ,output logic [data_w_lp-1:0] data_mem_pkt_o
  ,input  logic                 data_mem_pkt_yumi_i

  ,output logic [1:0]           owner_o
  );

  typedef enum logic [1:0] {
    e_idle      = 2'b00,
    e_fill_lock = 2'b01,
    e_cmd_lock  = 2'b10
  } state_e;

  state_e        state_d, state_q;
  bp_lce_grant_e grant_s;

  logic                 fill_any_v_s, cmd_any_v_s;
  logic                 starve_sat_s;
  logic [starve_w_lp-1:0] starve_cnt_s;
  logic                 tag_v_s, data_v_s, tag_last_s, data_last_s;
  logic [tag_w_lp-1:0]  tag_pkt_s;
  logic [data_w_lp-1:0] data_pkt_s;
  logic                 tag_acc_s, data_acc_s, any_acc_s, release_s;
  logic                 cmd_yumi_s;

  assign fill_any_v_s = fill_tag_v_i | fill_data_v_i;
  assign cmd_any_v_s  = cmd_tag_v_i  | cmd_data_v_i;

  // Winner selection; reset forces no grant so every output drops with it.
  always_comb begin
    grant_s = e_grant_none;
    if (!reset_n_i) begin
      grant_s = e_grant_none;
    end else begin
      case (state_q)
        e_fill_lock: grant_s = e_grant_fill;
        e_cmd_lock:  grant_s = e_grant_cmd;
        e_idle: begin
          if (starve_sat_s && cmd_any_v_s) begin
            grant_s = e_grant_cmd;
          end else if (fill_any_v_s) begin
            grant_s = e_grant_fill;
          end else if (cmd_any_v_s) begin
            grant_s = e_grant_cmd;
          end else begin
            grant_s = e_grant_none;
          end
        end
        default: grant_s = e_grant_none;
      endcase
    end
  end

  // Zero-latency mux of the winner's packets; nothing from the loser leaks through.
  always_comb begin
    tag_v_s     = 1'b0;
    tag_pkt_s   = '0;
    tag_last_s  = 1'b0;
    data_v_s    = 1'b0;
    data_pkt_s  = '0;
    data_last_s = 1'b0;
    case (grant_s)
      e_grant_fill: begin
        tag_v_s     = fill_tag_v_i;
        tag_pkt_s   = fill_tag_i;
        tag_last_s  = fill_tag_last_i;
        data_v_s    = fill_data_v_i;
        data_pkt_s  = fill_data_i;
        data_last_s = fill_data_last_i;
      end
      e_grant_cmd: begin
        tag_v_s     = cmd_tag_v_i;
        tag_pkt_s   = cmd_tag_i;
        tag_last_s  = cmd_tag_last_i;
        data_v_s    = cmd_data_v_i;
        data_pkt_s  = cmd_data_i;
        data_last_s = cmd_data_last_i;
      end
      default: begin
        tag_v_s     = 1'b0;
        tag_pkt_s   = '0;
        tag_last_s  = 1'b0;
        data_v_s    = 1'b0;
        data_pkt_s  = '0;
        data_last_s = 1'b0;
      end
    endcase
  end

  // A cache yumi without a matching valid is ignored.
  assign tag_acc_s  = tag_v_s  & tag_mem_pkt_yumi_i;
  assign data_acc_s = data_v_s & data_mem_pkt_yumi_i;
  assign any_acc_s  = tag_acc_s | data_acc_s;
  assign release_s  = (tag_acc_s & tag_last_s) | (data_acc_s & data_last_s);

  assign tag_mem_pkt_v_o  = tag_v_s;
  assign tag_mem_pkt_o    = tag_pkt_s;
  assign data_mem_pkt_v_o = data_v_s;
  assign data_mem_pkt_o   = data_pkt_s;

  assign fill_tag_yumi_o  = tag_acc_s  & (grant_s == e_grant_fill);
  assign fill_data_yumi_o = data_acc_s & (grant_s == e_grant_fill);
  assign cmd_tag_yumi_o   = tag_acc_s  & (grant_s == e_grant_cmd);
  assign cmd_data_yumi_o  = data_acc_s & (grant_s == e_grant_cmd);
  assign cmd_yumi_s       = cmd_tag_yumi_o | cmd_data_yumi_o;

  assign owner_o = grant_s;

  // Ownership: lock on a non-final acceptance, release on any accepted last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_idle: begin
        if (any_acc_s && !release_s) begin
          case (grant_s)
            e_grant_fill: state_d = e_fill_lock;
            e_grant_cmd:  state_d = e_cmd_lock;
            default:      state_d = e_idle;
          endcase
        end else begin
          state_d = e_idle;
        end
      end
      e_fill_lock, e_cmd_lock: begin
        if (release_s) begin
          state_d = e_idle;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = e_idle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
    end else begin
      state_q <= state_d;
    end
  end

  bp_lce_mem_pkt_arbiter_starve_cnt
   #(.max_val_p(starve_limit_p)
    ,.width_p  (starve_w_lp))
   starve_cnt
    (.clk_i    (clk_i)
    ,.reset_n_i(reset_n_i)
    ,.clear_i  (cmd_yumi_s)
    ,.up_i     (cmd_any_v_s & ~cmd_yumi_s)
    ,.count_o  (starve_cnt_s)
    ,.sat_o    (starve_sat_s)
    );

endmodule

// File: tb/tb_bp_lce_mem_pkt_arbiter.sv
// Self-checking bench for bp_lce_mem_pkt_arbiter: directed scenarios plus a
// randomized run against a transaction-level ownership model.
module tb_bp_lce_mem_pkt_arbiter;

  localparam int TAG_W  = 12;
  localparam int DATA_W = 16;
  localparam int STARVE = 8;

  logic clk = 1'b0;
  logic reset_n;

  logic              fill_tag_v, fill_tag_last, fill_tag_yumi;
  logic [TAG_W-1:0]  fill_tag;
  logic              fill_data_v, fill_data_last, fill_data_yumi;
  logic [DATA_W-1:0] fill_data;
  logic              cmd_tag_v, cmd_tag_last, cmd_tag_yumi;
  logic [TAG_W-1:0]  cmd_tag;
  logic              cmd_data_v, cmd_data_last, cmd_data_yumi;
  logic [DATA_W-1:0] cmd_data;
  logic              tag_v, tag_yumi, data_v, data_yumi;
  logic [TAG_W-1:0]  tag_pkt;
  logic [DATA_W-1:0] data_pkt;
  logic [1:0]        owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_lce_mem_pkt_arbiter #(
    .tag_pkt_width_p (TAG_W),
    .data_pkt_width_p(DATA_W),
    .starve_limit_p  (STARVE)
  ) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .fill_tag_v_i       (fill_tag_v),
    .fill_tag_i         (fill_tag),
    .fill_tag_last_i    (fill_tag_last),
    .fill_tag_yumi_o    (fill_tag_yumi),
    .fill_data_v_i      (fill_data_v),
    .fill_data_i        (fill_data),
    .fill_data_last_i   (fill_data_last),
    .fill_data_yumi_o   (fill_data_yumi),
    .cmd_tag_v_i        (cmd_tag_v),
    .cmd_tag_i          (cmd_tag),
    .cmd_tag_last_i     (cmd_tag_last),
    .cmd_tag_yumi_o     (cmd_tag_yumi),
    .cmd_data_v_i       (cmd_data_v),
    .cmd_data_i         (cmd_data),
    .cmd_data_last_i    (cmd_data_last),
    .cmd_data_yumi_o    (cmd_data_yumi),
    .tag_mem_pkt_v_o    (tag_v),
    .tag_mem_pkt_o      (tag_pkt),
    .tag_mem_pkt_yumi_i (tag_yumi),
    .data_mem_pkt_v_o   (data_v),
    .data_mem_pkt_o     (data_pkt),
    .data_mem_pkt_yumi_i(data_yumi),
    .owner_o            (owner)
  );

  task automatic drive(input logic fvt, input logic flt, input logic fvd, input logic fld,
                       input logic cvt, input logic clt, input logic cvd, input logic cld,
                       input logic ty, input logic dy);
    fill_tag_v = fvt; fill_tag_last = flt; fill_data_v = fvd; fill_data_last = fld;
    cmd_tag_v  = cvt; cmd_tag_last  = clt; cmd_data_v  = cvd; cmd_data_last  = cld;
    tag_yumi = ty; data_yumi = dy;
    fill_tag  = TAG_W'($urandom);  cmd_tag  = TAG_W'($urandom);
    fill_data = DATA_W'($urandom); cmd_data = DATA_W'($urandom);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1, 0, 1, 0, 1, 0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({fill_tag_yumi, fill_data_yumi, cmd_tag_yumi, cmd_data_yumi, tag_v, data_v, owner} !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs: got %b expected 00000000",
                 {fill_tag_yumi, fill_data_yumi, cmd_tag_yumi, cmd_data_yumi, tag_v, data_v, owner});
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
  endtask

  task automatic test_fill_lock();
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 1, 0, 0, 1, 1); #1;
    checks++;
    if (owner !== 2'b01 || fill_tag_yumi !== 1'b1 || cmd_tag_yumi !== 1'b0 || tag_pkt !== fill_tag) begin
      errors++;
      $display("FAIL fill_lock_tag: owner=%b fyumi=%b cyumi=%b pkt=%h expected owner=01 fyumi=1 cyumi=0 pkt=%h",
               owner, fill_tag_yumi, cmd_tag_yumi, tag_pkt, fill_tag);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(0, 0, 1, (i == 4), 1, 1, 0, 0, 1, 1); #1;
      checks++;
      if (owner !== 2'b01 || cmd_tag_yumi !== 1'b0 || fill_data_yumi !== 1'b1 ||
          data_pkt !== fill_data || tag_v !== 1'b0) begin
        errors++;
        $display("FAIL fill_lock_beat%0d: owner=%b cyumi=%b fdyumi=%b tag_v=%b expected owner=01 cyumi=0 fdyumi=1 tag_v=0",
                 i, owner, cmd_tag_yumi, fill_data_yumi, tag_v);
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 0, 0, 1, 1); #1;
    checks++;
    if (owner !== 2'b10 || cmd_tag_yumi !== 1'b1 || tag_pkt !== cmd_tag) begin
      errors++;
      $display("FAIL fill_lock_release: owner=%b cyumi=%b expected owner=10 cyumi=1", owner, cmd_tag_yumi);
    end
    idle_cycle();
  endtask

  task automatic test_starvation();
    for (int i = 0; i <= 9; i++) begin
      logic exp_cmd;
      exp_cmd = (i == STARVE);
      @(negedge clk);
      drive(1, 1, 0, 0, 1, 1, 0, 0, 1, 0); #1;
      checks++;
      if (owner !== (exp_cmd ? 2'b10 : 2'b01) || fill_tag_yumi !== !exp_cmd || cmd_tag_yumi !== exp_cmd) begin
        errors++;
        $display("FAIL starvation_cycle%0d: owner=%b fyumi=%b cyumi=%b expected owner=%b fyumi=%b cyumi=%b",
                 i, owner, fill_tag_yumi, cmd_tag_yumi, exp_cmd ? 2'b10 : 2'b01, !exp_cmd, exp_cmd);
      end
    end
    idle_cycle();
  endtask

  task automatic test_cmd_hold();
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 1, 0); #1;
    checks++;
    if (owner !== 2'b10 || cmd_tag_yumi !== 1'b1) begin
      errors++;
      $display("FAIL cmd_hold_start: owner=%b cyumi=%b expected owner=10 cyumi=1", owner, cmd_tag_yumi);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      else       drive(1, 1, 0, 0, 1, 0, 1, 1, 0, 1);
      #1;
      checks++;
      if (owner !== 2'b10 || tag_v !== 1'b1 || tag_pkt !== cmd_tag || fill_tag_yumi !== 1'b0 ||
          cmd_data_yumi !== (i == 4)) begin
        errors++;
        $display("FAIL cmd_hold_cycle%0d: owner=%b tag_v=%b pkt=%h fyumi=%b cdyumi=%b expected owner=10 tag_v=1 pkt=%h fyumi=0 cdyumi=%b",
                 i, owner, tag_v, tag_pkt, fill_tag_yumi, cmd_data_yumi, cmd_tag, (i == 4));
      end
    end
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 0); #1;
    checks++;
    if (owner !== 2'b01 || fill_tag_yumi !== 1'b1 || tag_pkt !== fill_tag) begin
      errors++;
      $display("FAIL cmd_hold_release: owner=%b fyumi=%b expected owner=01 fyumi=1", owner, fill_tag_yumi);
    end
    idle_cycle();
  endtask

  task automatic test_same_cycle_release();
    for (int v = 0; v < 2; v++) begin
      logic tl, dl;
      tl = (v == 1);
      dl = (v == 0);
      @(negedge clk);
      drive(1, 0, 0, 0, 1, 1, 0, 0, 1, 1); #1;
      @(negedge clk);
      drive(1, tl, 1, dl, 1, 1, 0, 0, 1, 1); #1;
      checks++;
      if (owner !== 2'b01 || fill_tag_yumi !== 1'b1 || fill_data_yumi !== 1'b1 || cmd_tag_yumi !== 1'b0) begin
        errors++;
        $display("FAIL same_cycle_accept_v%0d: owner=%b fty=%b fdy=%b cty=%b expected owner=01 fty=1 fdy=1 cty=0",
                 v, owner, fill_tag_yumi, fill_data_yumi, cmd_tag_yumi);
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 1, 0, 0, 1, 1); #1;
      checks++;
      if (owner !== 2'b10 || cmd_tag_yumi !== 1'b1) begin
        errors++;
        $display("FAIL same_cycle_release_v%0d: owner=%b cty=%b expected owner=10 cty=1", v, owner, cmd_tag_yumi);
      end
      idle_cycle();
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); #1;
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 1, 1); #1;
    checks++;
    if (owner !== 2'b01 || fill_data_yumi !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_lock: owner=%b fdy=%b expected owner=01 fdy=1", owner, fill_data_yumi);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({fill_tag_yumi, fill_data_yumi, cmd_tag_yumi, cmd_data_yumi, tag_v, data_v, owner} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset_drop: got %b expected 00000000",
               {fill_tag_yumi, fill_data_yumi, cmd_tag_yumi, cmd_data_yumi, tag_v, data_v, owner});
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 1, 1, 0, 0, 1, 1); #1;
    checks++;
    if (owner !== 2'b10 || cmd_tag_yumi !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_after: owner=%b cty=%b expected owner=10 cty=1", owner, cmd_tag_yumi);
    end
    idle_cycle();
  endtask

  task automatic test_spurious_yumi();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); #1;
      checks++;
      if ({fill_tag_yumi, fill_data_yumi, cmd_tag_yumi, cmd_data_yumi, tag_v, data_v, owner} !== 8'h00) begin
        errors++;
        $display("FAIL spurious_yumi_cycle%0d: got %b expected 00000000", i,
                 {fill_tag_yumi, fill_data_yumi, cmd_tag_yumi, cmd_data_yumi, tag_v, data_v, owner});
      end
    end
    @(negedge clk);
    drive(1, 1, 0, 0, 1, 1, 0, 0, 1, 1); #1;
    checks++;
    if (owner !== 2'b01 || fill_tag_yumi !== 1'b1 || cmd_tag_yumi !== 1'b0) begin
      errors++;
      $display("FAIL spurious_yumi_after: owner=%b fty=%b cty=%b expected owner=01 fty=1 cty=0",
               owner, fill_tag_yumi, cmd_tag_yumi);
    end
    idle_cycle();
  endtask

  // Reference: lock owner (0 none, 1 fill, 2 cmd) and Command's wait count.
  task automatic test_random();
    int m_lock, m_wait, w;
    logic fv, cv, etv, edv, etl, edl, acc_t, acc_d;
    logic [1:0] eown;
    logic [7:0] got, exp;
    @(negedge clk);
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_lock = 0;
    m_wait = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      #1;
      fv = fill_tag_v | fill_data_v;
      cv = cmd_tag_v | cmd_data_v;
      if (m_lock != 0) w = m_lock;
      else if (m_wait == STARVE && cv) w = 2;
      else if (fv) w = 1;
      else if (cv) w = 2;
      else w = 0;
      eown = (w == 1) ? 2'b01 : (w == 2) ? 2'b10 : 2'b00;
      etv  = (w == 1) ? fill_tag_v : (w == 2) ? cmd_tag_v : 1'b0;
      edv  = (w == 1) ? fill_data_v : (w == 2) ? cmd_data_v : 1'b0;
      etl  = (w == 1) ? fill_tag_last : cmd_tag_last;
      edl  = (w == 1) ? fill_data_last : cmd_data_last;
      acc_t = etv && tag_yumi;
      acc_d = edv && data_yumi;
      exp = {eown, etv, edv, acc_t && w == 1, acc_d && w == 1, acc_t && w == 2, acc_d && w == 2};
      got = {owner, tag_v, data_v, fill_tag_yumi, fill_data_yumi, cmd_tag_yumi, cmd_data_yumi};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_ctrl_cycle%0d: got %b expected %b (owner,tv,dv,fty,fdy,cty,cdy)", i, got, exp);
      end
      if (w != 0) begin
        checks++;
        if (tag_pkt !== ((w == 1) ? fill_tag : cmd_tag) || data_pkt !== ((w == 1) ? fill_data : cmd_data)) begin
          errors++;
          $display("FAIL random_pkt_cycle%0d: tag=%h data=%h expected tag=%h data=%h", i, tag_pkt, data_pkt,
                   (w == 1) ? fill_tag : cmd_tag, (w == 1) ? fill_data : cmd_data);
        end
      end
      if (acc_t || acc_d) m_lock = ((acc_t && etl) || (acc_d && edl)) ? 0 : w;
      if (w == 2 && (acc_t || acc_d)) m_wait = 0;
      else if (cv && m_wait < STARVE) m_wait = m_wait + 1;
    end
    idle_cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_fill_lock();
    test_starvation();
    test_cmd_hold();
    test_same_cycle_release();
    test_async_reset();
    test_spurious_yumi();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
